// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver (2-FF sync, 3-sample majority vote, parity/framing/break/overrun).
// Build option UART_RX_FIFO_EN: FIFO_DEPTH-entry receive FIFO; otherwise a single holding register.
module uart_rx_param #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk_in,
   input  logic                 reset,
   input  logic                 rx,
   input  logic                 rd_en,
   output logic [DATA_BITS-1:0] dout,
   output logic                 dout_perr,
   output logic                 dout_ferr,
   output logic                 empty,
   output logic                 rcv,
   output logic                 break_det,
   output logic                 overrun
);
   localparam int DIV  = CLK_FREQ / (BAUD * OVERSAMPLE);
   localparam int DIVW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SCW  = $clog2(OVERSAMPLE);
   localparam int EW   = DATA_BITS + 2;
   localparam logic [DIVW-1:0] DIV_LAST     = DIVW'(DIV - 1);
   localparam logic [SCW-1:0]  SC_S0        = SCW'(OVERSAMPLE/2 - 1);
   localparam logic [SCW-1:0]  SC_S1        = SCW'(OVERSAMPLE/2);
   localparam logic [SCW-1:0]  SC_VOTE      = SCW'(OVERSAMPLE/2 + 1);
   localparam logic [SCW-1:0]  SC_LAST      = SCW'(OVERSAMPLE - 1);
   localparam logic [3:0]      BC_DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]      BC_STOP_LAST = 4'(STOP_BITS - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t               state_q, state_d;
   logic [DIVW-1:0]      div_q, div_d;
   logic [SCW-1:0]       sc_q, sc_d;
   logic [3:0]           bc_q, bc_d;
   logic [DATA_BITS-1:0] sh_q, sh_d;
   logic rx_s1_q, rx_s_q;
   logic s0_q, s0_d, s1_q, s1_d;
   logic perr_q, perr_d, ferr_q, ferr_d, zero_q, zero_d;
   logic wait_q, wait_d, done_q, done_d;
   logic tick, vote, exp_par;

   assign tick    = (div_q == DIV_LAST);
   assign div_d   = tick ? '0 : div_q + DIVW'(1);
   assign vote    = (s0_q & s1_q) | (s0_q & rx_s_q) | (s1_q & rx_s_q);
   assign exp_par = (PARITY == 1) ? ~(^sh_q) : (^sh_q);

   always_comb begin
      state_d = state_q;
      sc_d    = sc_q;
      bc_d    = bc_q;
      s0_d    = s0_q;
      s1_d    = s1_q;
      sh_d    = sh_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      zero_d  = zero_q;
      wait_d  = wait_q & ~rx_s_q;
      done_d  = 1'b0;
      if (tick) begin
         if (state_q == S_IDLE) begin
            sc_d = '0;
            // after a framing error the line may still be low; hold off until it idles high
            if (!rx_s_q && !wait_q) begin
               state_d = S_START;
               bc_d    = '0;
               perr_d  = 1'b0;
               ferr_d  = 1'b0;
               zero_d  = 1'b1;
            end
         end else begin
            sc_d = (sc_q == SC_LAST) ? '0 : sc_q + SCW'(1);
            if (sc_q == SC_S0) s0_d = rx_s_q;
            if (sc_q == SC_S1) s1_d = rx_s_q;
            if (sc_q == SC_VOTE) begin
               if (vote) zero_d = 1'b0;
               case (state_q)
                  S_START:  if (vote) begin
                     state_d = S_IDLE;
                     sc_d    = '0;
                  end
                  S_DATA:   sh_d = {vote, sh_q[DATA_BITS-1:1]};
                  S_PARITY: perr_d = (vote != exp_par);
                  S_STOP: begin
                     if (!vote) ferr_d = 1'b1;
                     if (bc_q == BC_STOP_LAST) begin
                        state_d = S_IDLE;
                        sc_d    = '0;
                        done_d  = 1'b1;
                        wait_d  = ferr_q | ~vote;
                     end
                  end
                  default: ;
               endcase
            end
            if (sc_q == SC_LAST) begin
               case (state_q)
                  S_START: begin
                     state_d = S_DATA;
                     bc_d    = '0;
                  end
                  S_DATA: begin
                     if (bc_q == BC_DATA_LAST) begin
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                        bc_d    = '0;
                     end else begin
                        bc_d = bc_q + 4'd1;
                     end
                  end
                  S_PARITY: begin
                     state_d = S_STOP;
                     bc_d    = '0;
                  end
                  S_STOP:  bc_d = bc_q + 4'd1;
                  default: ;
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         div_q   <= '0;
         sc_q    <= '0;
         bc_q    <= '0;
         sh_q    <= '0;
         rx_s1_q <= 1'b1;
         rx_s_q  <= 1'b1;
         s0_q    <= 1'b0;
         s1_q    <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         zero_q  <= 1'b0;
         wait_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         sc_q    <= sc_d;
         bc_q    <= bc_d;
         sh_q    <= sh_d;
         rx_s1_q <= rx;
         rx_s_q  <= rx_s1_q;
         s0_q    <= s0_d;
         s1_q    <= s1_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         zero_q  <= zero_d;
         wait_q  <= wait_d;
         done_q  <= done_d;
      end
   end

   logic          full, pop, push;
   logic [EW-1:0] wdata;

   // frame fields stay stable in the completion cycle: the next START needs another tick
   assign wdata     = {perr_q, ferr_q, sh_q};
   assign pop       = rd_en & ~empty;
   assign push      = done_q & (~full | pop);
   assign rcv       = done_q;
   assign break_det = done_q & zero_q;
   assign overrun   = done_q & full & ~pop;

`ifdef UART_RX_FIFO_EN
   localparam int AW = $clog2(FIFO_DEPTH);
   logic [EW-1:0] mem_q [FIFO_DEPTH];
   logic [AW:0]   wp_q, rp_q;

   assign empty = (wp_q == rp_q);
   assign full  = (wp_q == {~rp_q[AW], rp_q[AW-1:0]});

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         wp_q <= '0;
         rp_q <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (push) begin
            mem_q[wp_q[AW-1:0]] <= wdata;
            wp_q <= wp_q + (AW+1)'(1);
         end
         if (pop) rp_q <= rp_q + (AW+1)'(1);
      end
   end

   assign {dout_perr, dout_ferr, dout} = mem_q[rp_q[AW-1:0]];
`else
   localparam int unused_fifo_depth = FIFO_DEPTH;
   logic          vld_q;
   logic [EW-1:0] hold_q;

   assign empty = ~vld_q;
   assign full  = vld_q;

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         vld_q  <= 1'b0;
         hold_q <= '0;
      end else begin
         if (push) hold_q <= wdata;
         vld_q <= push | (vld_q & ~pop);
      end
   end

   assign {dout_perr, dout_ferr, dout} = hold_q;
`endif

endmodule
